// File: rtl/addr_access_fsm.sv
// Multi-cycle sequencer for the array index / array amend instructions.
// Optional amend support is enabled by defining ADDR_ACCESS_AMEND_EN.

package addr_access_pkg;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] data;
    logic        mode;
  } reg_in_bus_t;

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] address;
    logic [31:0] offset;
    logic [31:0] data;
  } mem_in_bus_t;

  typedef enum logic [3:0] {
    S_IDLE,
`ifdef ADDR_ACCESS_AMEND_EN
    S_RD_A,
    S_MEM_WR,
`endif
    S_RD_B,
    S_RD_C,
    S_MEM_RD,
    S_MEM_WAIT,
    S_WR_A,
    S_DONE
  } state_t;

endpackage

module addr_access_fsm
  import addr_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        op,
  input  logic [2:0]  regA,
  input  logic [2:0]  regB,
  input  logic [2:0]  regC,
  input  logic [31:0] reg_data_out,
  input  logic [31:0] mem_out,
  output reg_in_bus_t reg_in,
  output mem_in_bus_t mem_in,
  output logic        finished,
  output state_t      state_dbg
);

  // Handshake: enable is a level request. It is sampled on every edge; while
  // high the sequence advances, dropping it returns to IDLE on the next edge
  // with no write issued. finished rises on the second DONE cycle and falls on
  // the edge that sees enable low, so a new run needs one low cycle between.

  state_t      state, next_state;
  logic [2:0]  sel_a_q, sel_b_q, sel_c_q;
  logic [31:0] addr_q, off_q, data_q;
  logic        finished_q;
  logic        amend;
  logic        start_amend;

`ifdef ADDR_ACCESS_AMEND_EN
  logic op_q;
  assign amend       = op_q;
  assign start_amend = op;
`else
  logic unused_op;
  assign unused_op   = op;
  assign amend       = 1'b0;
  assign start_amend = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (state != S_IDLE && !enable) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
`ifdef ADDR_ACCESS_AMEND_EN
            next_state = start_amend ? S_RD_A : S_RD_B;
`else
            next_state = S_RD_B;
`endif
          end
        end
`ifdef ADDR_ACCESS_AMEND_EN
        S_RD_A:   next_state = S_RD_B;
        S_MEM_WR: next_state = S_DONE;
`endif
        S_RD_B:     next_state = S_RD_C;
`ifdef ADDR_ACCESS_AMEND_EN
        S_RD_C:     next_state = amend ? S_MEM_WR : S_MEM_RD;
`else
        S_RD_C:     next_state = S_MEM_RD;
`endif
        S_MEM_RD:   next_state = S_MEM_WAIT;
        S_MEM_WAIT: next_state = S_WR_A;
        S_WR_A:     next_state = S_DONE;
        S_DONE:     next_state = S_DONE;
        default:    next_state = S_IDLE;
      endcase
    end
  end

  // Register numbers are captured on start so outputs never follow decoder inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_a_q    <= '0;
      sel_b_q    <= '0;
      sel_c_q    <= '0;
      addr_q     <= '0;
      off_q      <= '0;
      data_q     <= '0;
      finished_q <= 1'b0;
`ifdef ADDR_ACCESS_AMEND_EN
      op_q       <= 1'b0;
`endif
    end else begin
      finished_q <= (state == S_DONE) && enable;
      case (state)
        S_IDLE: begin
          if (enable) begin
            sel_a_q <= regA;
            sel_b_q <= regB;
            sel_c_q <= regC;
`ifdef ADDR_ACCESS_AMEND_EN
            op_q    <= start_amend;
`endif
          end
        end
`ifdef ADDR_ACCESS_AMEND_EN
        S_RD_A: addr_q <= reg_data_out;
`endif
        S_RD_B: begin
          if (amend) off_q  <= reg_data_out;
          else       addr_q <= reg_data_out;
        end
        S_RD_C: begin
          if (amend) data_q <= reg_data_out;
          else       off_q  <= reg_data_out;
        end
        S_MEM_WAIT: data_q <= mem_out;
        default: ;
      endcase
    end
  end

  always_comb begin
    reg_in = '0;
    mem_in = '0;
    case (state)
`ifdef ADDR_ACCESS_AMEND_EN
      S_RD_A: reg_in.sel = sel_a_q;
      S_MEM_WR: begin
        mem_in.mode    = 2'b01;
        mem_in.address = addr_q;
        mem_in.offset  = off_q;
        mem_in.data    = data_q;
      end
`endif
      S_RD_B: reg_in.sel = sel_b_q;
      S_RD_C: reg_in.sel = sel_c_q;
      S_MEM_RD, S_MEM_WAIT: begin
        mem_in.mode    = 2'b00;
        mem_in.address = addr_q;
        mem_in.offset  = off_q;
      end
      S_WR_A: begin
        reg_in.sel  = sel_a_q;
        reg_in.data = data_q;
        reg_in.mode = 1'b1;
      end
      default: ;
    endcase
  end

  assign finished  = finished_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_addr_access_fsm.sv
// Bench for addr_access_fsm: register bank and memory models around the DUT,
// directed cases plus randomized runs checked against an instruction-level model.
module tb_addr_access_fsm;
  import addr_access_pkg::*;

`ifdef ADDR_ACCESS_AMEND_EN
  localparam bit AMEND_EN = 1'b1;
`else
  localparam bit AMEND_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        op;
  logic [2:0]  reg_a, reg_b, reg_c;
  logic [31:0] reg_data_out;
  logic [31:0] mem_out;
  reg_in_bus_t reg_in;
  mem_in_bus_t mem_in;
  logic        finished;
  state_t      state_dbg;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] regs [8];
  logic [31:0] mem_store [logic [63:0]];

  addr_access_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .op           (op),
    .regA         (reg_a),
    .regB         (reg_b),
    .regC         (reg_c),
    .reg_data_out (reg_data_out),
    .mem_out      (mem_out),
    .reg_in       (reg_in),
    .mem_in       (mem_in),
    .finished     (finished),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- environment models ----------------
  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [31:0] o);
    if (mem_store.exists({a, o})) return mem_store[{a, o}];
    return (a ^ {o[15:0], o[31:16]}) + 32'h1234_5678;
  endfunction

  assign reg_data_out = regs[reg_in.sel];

  always @(posedge clk) begin
    if (reg_in.mode) regs[reg_in.sel] = reg_in.data;
  end

  always @(posedge clk) begin
    if (mem_in.mode == 2'b00) mem_out <= mem_rd(mem_in.address, mem_in.offset);
    else if (mem_in.mode == 2'b01) mem_store[{mem_in.address, mem_in.offset}] = mem_in.data;
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_reg_in"}, reg_in, '0);
    check({tag, "_mem_in"}, mem_in, '0);
    check({tag, "_finished"}, finished, 0);
  endtask

  // ---------------- driver + reference model ----------------
  // Runs one instruction and compares its visible effects with the
  // instruction semantics: index A <- mem[B][C], amend mem[A][B] <- C.
  task automatic run_op(input logic op_i, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] c, input int hold);
    logic [31:0] snap [8];
    logic [31:0] exp_val;
    bit          amend_eff;
    int          fin_edge, reg_wr, mem_wr, reg_wr_edge, mem_wr_edge, diffs;
    logic [2:0]  wr_sel;
    logic [31:0] wr_data;
    mem_in_bus_t mw;

    snap      = regs;
    amend_eff = op_i && AMEND_EN;
    exp_val   = amend_eff ? snap[c] : mem_rd(snap[b], snap[c]);
    fin_edge = -1; reg_wr = 0; mem_wr = 0; reg_wr_edge = -1; mem_wr_edge = -1;
    wr_sel = '0; wr_data = '0; mw = '0;

    @(negedge clk);
    op = op_i; reg_a = a; reg_b = b; reg_c = c; enable = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (reg_in.mode) begin
        reg_wr++; reg_wr_edge = k + 1; wr_sel = reg_in.sel; wr_data = reg_in.data;
      end
      if (mem_in.mode == 2'b01) begin
        mem_wr++; mem_wr_edge = k + 1; mw = mem_in;
      end
      if (finished && fin_edge < 0) fin_edge = k;
      if (fin_edge >= 0 && k >= fin_edge + hold) break;
    end
    check("finish_edge", fin_edge, amend_eff ? 5 : 6);
    check("finish_hold", finished, 1);
    enable = 1'b0;
    @(negedge clk);
    check("finish_drop", finished, 0);
    check_idle("after_op");

    if (amend_eff) begin
      check("amend_mem_wr_count", mem_wr, 1);
      check("amend_reg_wr_count", reg_wr, 0);
      check("amend_wr_edge", mem_wr_edge, 4);
      check("amend_wr_addr", mw.address, snap[a]);
      check("amend_wr_off", mw.offset, snap[b]);
      check("amend_wr_data", mw.data, exp_val);
      check("amend_mem_content", mem_rd(snap[a], snap[b]), exp_val);
    end else begin
      check("index_reg_wr_count", reg_wr, 1);
      check("index_mem_wr_count", mem_wr, 0);
      check("index_wr_sel", wr_sel, a);
      check("index_wr_data", wr_data, exp_val);
      check("index_wr_before_finish", reg_wr_edge >= 1 && reg_wr_edge <= fin_edge, 1);
    end
    diffs = 0;
    for (int i = 0; i < 8; i++) begin
      if (regs[i] !== ((!amend_eff && i == a) ? exp_val : snap[i])) diffs++;
    end
    check("reg_bank_state", diffs, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r1_before;
    bit          seen;

    reset = 1'b1; enable = 1'b0; op = 1'b0; reg_a = '0; reg_b = '0; reg_c = '0;
    for (int i = 0; i < 8; i++) regs[i] = $urandom;
    #1;
    check_idle("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // Index directed case
    regs[2] = 32'h0; regs[4] = 32'h5555;
    mem_store[{32'h5555, 32'h0}] = 32'h7676_7676;
    mem_store[{32'h5555, 32'h1}] = 32'h1313_1313;
    run_op(1'b0, 3'd1, 3'd4, 3'd2, 0);
    check("index_reg1_value", regs[1], 32'h7676_7676);
    check("index_reg4_kept", regs[4], 32'h5555);

    // Amend directed case
    regs[1] = 32'hcccc; regs[4] = 32'h5555; regs[2] = 32'h5c5c_5c5c;
    run_op(1'b1, 3'd1, 3'd4, 3'd2, 0);
`ifdef ADDR_ACCESS_AMEND_EN
    check("amend_mem_cccc_5555", mem_rd(32'hcccc, 32'h5555), 32'h5c5c_5c5c);
`endif

    // Abort during MEM_RD
    regs[1] = 32'h0bad_f00d; regs[4] = 32'h5555; regs[2] = 32'h0;
    r1_before = regs[1];
    @(negedge clk);
    op = 1'b0; reg_a = 3'd1; reg_b = 3'd4; reg_c = 3'd2; enable = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_in_mem_rd_addr", mem_in.address, 32'h5555);
    enable = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (reg_in.mode || finished || mem_in.mode == 2'b01) seen = 1'b1;
    end
    check("abort_no_write_no_finish", seen, 0);
    check("abort_reg1_kept", regs[1], r1_before);
    check_idle("abort");

    // Reset during the register write cycle
    regs[2] = 32'h0; regs[4] = 32'h5555;
    @(negedge clk);
    op = 1'b0; reg_a = 3'd1; reg_b = 3'd4; reg_c = 3'd2; enable = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (reg_in.mode) seen = 1'b1;
    end
    check("reset_reached_write", seen, 1);
    #1 reset = 1'b1;
    #1 check_idle("reset_in_write");
    @(negedge clk);
    reset = 1'b0; enable = 1'b0;
    @(negedge clk);
    check_idle("reset_released");
    run_op(1'b0, 3'd1, 3'd4, 3'd2, 0);

    // Aliasing
    regs[3] = 32'h10;
    mem_store[{32'h10, 32'h10}] = 32'habcd;
    run_op(1'b0, 3'd3, 3'd3, 3'd3, 0);
    check("alias_reg3_value", regs[3], 32'habcd);

    // Hold enable after DONE
    run_op(1'b0, 3'd5, 3'd6, 3'd7, 5);
    run_op(1'b1, 3'd5, 3'd6, 3'd7, 5);

    // Randomized runs
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 8; i++) regs[i] = $urandom;
      if ($urandom_range(0, 1) == 1) regs[$urandom_range(0, 7)] = $urandom_range(0, 3);
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
